// File: rtl/multitap_n_if.sv
// Host-side port-register bus for the multitap: select, direction, write data,
// read data and bus acknowledge.
interface multitap_n_if;
   logic       sel;
   logic       rnw;
   logic [7:0] di;
   logic [7:0] dout;
   logic       dtack_n;

   modport master (output sel, output rnw, output di, input dout, input dtack_n);
   modport slave  (input sel, input rnw, input di, output dout, output dtack_n);
endinterface

// File: rtl/multitap_n.sv
// N-pad multitap adapter: TH/TR/TL nibble-serial handshake over a button
// snapshot taken at the TH fall, with a handshake timeout.
module multitap_n #(
   parameter int NUM_PADS = 4,
   parameter int TIMEOUT  = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   ce_i,
   input  logic [12*NUM_PADS-1:0] pad_btns_i,
   input  logic [2*NUM_PADS-1:0]  pad_type_i,
   multitap_n_if.slave            bus
);
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_e;

   localparam logic [6:0]  FIRST_DATA = 7'(4 + NUM_PADS);
   localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

   state_e                  state_q;
   logic                    th_q, tr_q, tl_q;
   logic [5:0]              idx_q;
   logic [3:0]              nib_q;
   logic [12*NUM_PADS-1:0]  snap_q;
   logic [2*NUM_PADS-1:0]   typ_q;
   logic [15:0]             tmr_q;
   logic [7:0]              do_q;
   logic                    dtack_n_q;
   logic [5:0]              idx_inc_d;
   logic [3:0]              nib_inc_d;
   logic                    unused_s;

   // Nibble at position idx: header, one type nibble per pad, then the data
   // nibbles of every present pad in ascending order (active-low buttons).
   function automatic logic [3:0] seq_nib(input logic [5:0]             idx,
                                          input logic [2*NUM_PADS-1:0]  typ,
                                          input logic [12*NUM_PADS-1:0] snap);
      logic [3:0]  nib;
      logic [6:0]  pos;
      logic [6:0]  i;
      logic [6:0]  cnt;
      logic [1:0]  t;
      logic [11:0] b;
      nib = 4'hF;
      pos = FIRST_DATA;
      i   = {1'b0, idx};
      for (int p = 0; p < NUM_PADS; p++) begin
         t = typ[2*p +: 2];
         b = snap[12*p +: 12];
         case (t)
            2'b01:   cnt = 7'd2;
            2'b10:   cnt = 7'd3;
            default: cnt = 7'd0;
         endcase
         if (i == 7'(4 + p)) begin
            case (t)
               2'b01:   nib = 4'h0;
               2'b10:   nib = 4'h1;
               default: nib = 4'hF;
            endcase
         end else if ((i >= pos) && (i < (pos + cnt))) begin
            case (i - pos)
               7'd0:    nib = ~b[3:0];
               7'd1:    nib = ~{b[7], b[4], b[6], b[5]};
               default: nib = ~{b[8], b[9], b[10], b[11]};
            endcase
         end
         pos = pos + cnt;
      end
      if (i == 7'd0) begin
         nib = 4'h3;
      end else if (i == 7'd1) begin
         nib = 4'hF;
      end else if (i < 7'd4) begin
         nib = 4'h0;
      end
      return nib;
   endfunction

   // Next handshake position, saturating at the top of the index range.
   always_comb begin
      if (idx_q == 6'd63) begin
         idx_inc_d = 6'd63;
      end else begin
         idx_inc_d = idx_q + 6'd1;
      end
      nib_inc_d = seq_nib(idx_inc_d, typ_q, snap_q);
   end

   // Port registers, handshake FSM, timeout and registered bus outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         th_q      <= 1'b1;
         tr_q      <= 1'b1;
         tl_q      <= 1'b1;
         idx_q     <= 6'd0;
         nib_q     <= 4'h3;
         snap_q    <= '0;
         typ_q     <= '0;
         tmr_q     <= 16'd0;
         do_q      <= 8'h73;
         dtack_n_q <= 1'b1;
      end else if (ce_i) begin
         if (bus.sel && !bus.rnw) begin
            th_q <= bus.di[6];
            tr_q <= bus.di[5];
         end
         dtack_n_q <= ~bus.sel;
         // Bit 4 has no source and reads back high.
         do_q      <= {1'b0, th_q, tl_q, 1'b1, nib_q};
         if (th_q) begin
            state_q <= ST_IDLE;
            idx_q   <= 6'd0;
            nib_q   <= 4'h3;
            tl_q    <= tr_q;
            tmr_q   <= 16'd0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= ST_XFER;
                  snap_q  <= pad_btns_i;
                  typ_q   <= pad_type_i;
                  idx_q   <= 6'd0;
                  nib_q   <= 4'h3;
                  tl_q    <= tr_q;
                  tmr_q   <= 16'd0;
               end
               ST_XFER: begin
                  if (tr_q != tl_q) begin
                     idx_q <= idx_inc_d;
                     nib_q <= nib_inc_d;
                     tl_q  <= tr_q;
                     tmr_q <= 16'd0;
                  end else if (tmr_q == TMO_LAST) begin
                     idx_q <= 6'd0;
                     nib_q <= 4'h3;
                     tl_q  <= tr_q;
                     tmr_q <= 16'd0;
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.dout    = do_q;
   assign bus.dtack_n = dtack_n_q;
   assign unused_s    = ^{bus.di[7], bus.di[4:0]};
endmodule

// File: tb/tb_multitap_n.sv
// Bench for multitap_n: a 4-pad and an 8-pad instance share one host bus and are
// compared every cycle against a queue-based sequence model plus fixed vectors.
module tb_multitap_n;
   localparam int TMO = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce;
   logic [47:0] btn4;
   logic [7:0]  typ4;
   logic [95:0] btn8;
   logic [15:0] typ8;

   multitap_n_if bus4 ();
   multitap_n_if bus8 ();

   multitap_n #(.NUM_PADS(4), .TIMEOUT(TMO)) u4 (
      .clk_i(clk), .rst_ni(rst_n), .ce_i(ce),
      .pad_btns_i(btn4), .pad_type_i(typ4), .bus(bus4));
   multitap_n #(.NUM_PADS(8), .TIMEOUT(TMO)) u8 (
      .clk_i(clk), .rst_ni(rst_n), .ce_i(ce),
      .pad_btns_i(btn8), .pad_type_i(typ8), .bus(bus8));

   always #5 clk = ~clk;

   typedef struct {
      logic        th, tr, tl, xfer;
      int          idx;
      logic [3:0]  nib;
      int          tmr;
      logic [95:0] snap;
      logic [15:0] typ;
      logic [7:0]  dout;
      logic        dtack_n;
   } model_t;

   typedef struct {
      logic [7:0] di;
      logic [7:0] exp_do;
   } vec_t;

   model_t m4, m8;
   vec_t   tbl[16];
   int     errors = 0;
   int     checks = 0;

   // Full transmit list built from the snapshot; anything past its end reads 0xF.
   function automatic logic [3:0] ref_nib(input int np, input logic [15:0] typ,
                                          input logic [95:0] snap, input int i);
      logic [3:0]  q[$];
      logic [1:0]  t;
      logic [11:0] b;
      q.push_back(4'h3); q.push_back(4'hF); q.push_back(4'h0); q.push_back(4'h0);
      for (int p = 0; p < np; p++) begin
         t = typ[2*p +: 2];
         q.push_back(t == 2'b01 ? 4'h0 : (t == 2'b10 ? 4'h1 : 4'hF));
      end
      for (int p = 0; p < np; p++) begin
         t = typ[2*p +: 2];
         b = snap[12*p +: 12];
         if (t == 2'b01 || t == 2'b10) begin
            q.push_back(~{b[3], b[2], b[1], b[0]});
            q.push_back(~{b[7], b[4], b[6], b[5]});
         end
         if (t == 2'b10) q.push_back(~{b[8], b[9], b[10], b[11]});
      end
      return (i < q.size()) ? q[i] : 4'hF;
   endfunction

   function automatic model_t model_step(input model_t m, input int np, input logic rst,
                                         input logic c, input logic s, input logic r,
                                         input logic [7:0] d, input logic [95:0] btns,
                                         input logic [15:0] typ);
      model_t n;
      n = m;
      if (!rst) begin
         n.th = 1'b1; n.tr = 1'b1; n.tl = 1'b1; n.xfer = 1'b0; n.idx = 0;
         n.nib = 4'h3; n.tmr = 0; n.snap = '0; n.typ = '0;
         n.dout = 8'h73; n.dtack_n = 1'b1;
      end else if (c) begin
         n.dtack_n = !s;
         n.dout = {1'b0, m.th, m.tl, 1'b1, m.nib};
         if (m.th) begin
            n.xfer = 1'b0; n.idx = 0; n.nib = 4'h3; n.tl = m.tr; n.tmr = 0;
         end else if (!m.xfer) begin
            n.xfer = 1'b1; n.snap = btns; n.typ = typ;
            n.idx = 0; n.nib = 4'h3; n.tl = m.tr; n.tmr = 0;
         end else if (m.tr != m.tl) begin
            n.idx = (m.idx < 63) ? m.idx + 1 : 63;
            n.nib = ref_nib(np, m.typ, m.snap, n.idx);
            n.tl = m.tr; n.tmr = 0;
         end else if (m.tmr == TMO - 1) begin
            n.idx = 0; n.nib = 4'h3; n.tmr = 0;
         end else begin
            n.tmr = m.tmr + 1;
         end
         if (s && !r) begin
            n.th = d[6];
            n.tr = d[5];
         end
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic s, input logic r, input logic [7:0] d,
                       input logic c, input logic rn);
      bus4.sel = s; bus4.rnw = r; bus4.di = d;
      bus8.sel = s; bus8.rnw = r; bus8.di = d;
      ce = c; rst_n = rn;
      @(posedge clk);
      m4 = model_step(m4, 4, rn, c, s, r, d, {48'b0, btn4}, {8'b0, typ4});
      m8 = model_step(m8, 8, rn, c, s, r, d, btn8, typ8);
      #1;
      chk("do4", bus4.dout, m4.dout);
      chk("dtack4", {7'b0, bus4.dtack_n}, {7'b0, m4.dtack_n});
      chk("do8", bus8.dout, m8.dout);
      chk("dtack8", {7'b0, bus8.dtack_n}, {7'b0, m8.dtack_n});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
   endtask

   task automatic wr(input logic [7:0] d);
      step(1'b1, 1'b0, d, 1'b1, 1'b1);
   endtask

   initial begin
      logic [7:0] d;
      tbl[0]  = '{8'h20, 8'h33}; tbl[1]  = '{8'h00, 8'h1F};
      tbl[2]  = '{8'h20, 8'h30}; tbl[3]  = '{8'h00, 8'h10};
      tbl[4]  = '{8'h20, 8'h30}; tbl[5]  = '{8'h00, 8'h11};
      tbl[6]  = '{8'h20, 8'h3F}; tbl[7]  = '{8'h00, 8'h10};
      tbl[8]  = '{8'h20, 8'h3F}; tbl[9]  = '{8'h00, 8'h1B};
      tbl[10] = '{8'h20, 8'h3F}; tbl[11] = '{8'h00, 8'h1F};
      tbl[12] = '{8'h20, 8'h3E}; tbl[13] = '{8'h00, 8'h1F};
      tbl[14] = '{8'h20, 8'h3F}; tbl[15] = '{8'h00, 8'h1F};

      btn4 = {12'h000, 12'h000, 12'h800, 12'h010};
      typ4 = 8'b01_00_10_01;
      btn8 = '0;
      btn8[92] = 1'b1;
      typ8 = 16'hAAAA;

      // Reset state and a side-effect-free read.
      step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      chk("reset_do", bus4.dout, 8'h73);
      chk("reset_dtack", {7'b0, bus4.dtack_n}, 8'h01);
      step(1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
      chk("read_dtack", {7'b0, bus4.dtack_n}, 8'h00);
      chk("read_do", bus4.dout, 8'h73);
      idle(1);
      chk("release_dtack", {7'b0, bus4.dtack_n}, 8'h01);

      // Directed 4-pad sequence; pads change after the snapshot.
      for (int i = 0; i < 16; i++) begin
         wr(tbl[i].di);
         idle(2);
         chk($sformatf("seq%0d", i), bus4.dout, tbl[i].exp_do);
         if (i == 0) begin
            btn4 = '1;
            typ4 = 8'hAA;
         end
      end
      btn4 = {12'h000, 12'h000, 12'h800, 12'h010};
      typ4 = 8'b01_00_10_01;

      // Timeout boundary.
      wr(8'h60); idle(2); chk("to_idle", bus4.dout, 8'h73);
      wr(8'h20); idle(2); chk("to_start", bus4.dout, 8'h33);
      wr(8'h00); idle(2); chk("to_n1", bus4.dout, 8'h1F);
      wr(8'h20); idle(2); chk("to_n2", bus4.dout, 8'h30);
      idle(TMO - 1);      chk("tmo_before", bus4.dout, 8'h30);
      idle(1);            chk("tmo_fire", bus4.dout, 8'h33);

      // Reset mid-transfer with CE low, then restart.
      wr(8'h00); idle(2); chk("rst_pre", bus4.dout, 8'h1F);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      chk("rst_mid_do", bus4.dout, 8'h73);
      wr(8'h20); idle(2); chk("rst_restart", bus4.dout, 8'h33);
      wr(8'h00); idle(2); chk("rst_n1", bus4.dout, 8'h1F);
      wr(8'h60); idle(2); chk("th_priority", bus4.dout, 8'h73);

      // Eight 6-button pads: 36 nibbles, then 0xF with no index wrap.
      wr(8'h20); idle(2); chk("p8_start", bus8.dout, 8'h33);
      for (int t = 1; t <= 70; t++) begin
         d = (t % 2 == 1) ? 8'h00 : 8'h20;
         wr(d);
         idle(2);
         if (t == 4)  chk("p8_type0", {4'h0, bus8.dout[3:0]}, 8'h01);
         if (t == 35) chk("p8_last", {4'h0, bus8.dout[3:0]}, 8'h07);
         if (t == 36) chk("p8_past", {4'h0, bus8.dout[3:0]}, 8'h0F);
         if (t == 70) chk("p8_nowrap", {4'h0, bus8.dout[3:0]}, 8'h0F);
      end

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         logic s, r, c, rn, th, tr;
         s  = ($urandom % 3) == 0;
         r  = ($urandom % 2) == 0;
         th = ($urandom % 12) == 0;
         tr = $urandom % 2;
         d  = 8'($urandom);
         d[6] = th;
         d[5] = tr;
         c  = ($urandom % 4) != 0;
         rn = ($urandom % 300) != 0;
         if (($urandom % 50) == 0) begin
            btn4 = {$urandom, 16'($urandom)};
            typ4 = 8'($urandom);
            btn8 = {$urandom, $urandom, $urandom};
            typ8 = 16'($urandom);
         end
         step(s, r, d, c, rn);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
